// File: rtl/mux_rr_pkg.sv
// Shared types and defaults for the two-lane round-robin nibble recombiner.
// Lane index type, lane constants and default geometry.
package mux_rr_pkg;

  typedef logic [0:0] lane_t;

  localparam lane_t LANE_0 = 1'b0;
  localparam lane_t LANE_1 = 1'b1;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_DEPTH = 4;

endpackage

// File: rtl/mux_rr_4_bits_fifo_lane.sv
// Per-lane FIFO: registered count/pointers, combinational head output.
// Push to a full FIFO and pop of an empty FIFO are ignored.
module fifo_lane #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mux_rr_4_bits.sv
// Two-lane round-robin recombiner with registered valid/ready output.
// Optional even-parity output enabled by defining MUX_RR_PARITY_EN.
module mux_rr_4_bits
  import mux_rr_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] deMux_4_bits_0,
  input  logic             valid_0,
  input  logic [WIDTH-1:0] deMux_4_bits_1,
  input  logic             valid_1,
  input  logic             ready,
  output logic [WIDTH-1:0] bus_out,
  output logic             valid_out,
  output logic             lane_out,
  output logic             full_0,
  output logic             full_1,
  output logic             overflow_0,
  output logic             overflow_1
`ifdef MUX_RR_PARITY_EN
  ,
  output logic             parity_out
`endif
);

  logic [WIDTH-1:0] dout_0;
  logic [WIDTH-1:0] dout_1;
  logic             empty_0;
  logic             empty_1;
  logic             push_0;
  logic             push_1;
  logic             pop_0;
  logic             pop_1;
  logic             load;
  logic             gnt_vld;
  lane_t            gnt;
  lane_t            rr_ptr;
  lane_t            rr_nxt;
  logic [WIDTH-1:0] head;

  assign push_0 = valid_0 & ~full_0;
  assign push_1 = valid_1 & ~full_1;

  fifo_lane #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_lane_0 (
    .clk   (clk),
    .reset (reset),
    .push  (push_0),
    .din   (deMux_4_bits_0),
    .pop   (pop_0),
    .dout  (dout_0),
    .empty (empty_0),
    .full  (full_0)
  );

  fifo_lane #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_lane_1 (
    .clk   (clk),
    .reset (reset),
    .push  (push_1),
    .din   (deMux_4_bits_1),
    .pop   (pop_1),
    .dout  (dout_1),
    .empty (empty_1),
    .full  (full_1)
  );

  assign load = ~valid_out | ready;

  always_comb begin
    gnt_vld = 1'b0;
    gnt     = LANE_0;
    rr_nxt  = rr_ptr;
    if (load) begin
      unique case (1'b1)
        (~empty_0 & ~empty_1): begin
          gnt_vld = 1'b1;
          gnt     = rr_ptr;
          rr_nxt  = ~rr_ptr;
        end
        (~empty_0 & empty_1): begin
          gnt_vld = 1'b1;
          gnt     = LANE_0;
          rr_nxt  = LANE_1;
        end
        (empty_0 & ~empty_1): begin
          gnt_vld = 1'b1;
          gnt     = LANE_1;
          rr_nxt  = LANE_0;
        end
        default: begin
          gnt_vld = 1'b0;
        end
      endcase
    end
  end

  assign pop_0 = gnt_vld & (gnt == LANE_0);
  assign pop_1 = gnt_vld & (gnt == LANE_1);
  assign head  = (gnt == LANE_1) ? dout_1 : dout_0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr     <= LANE_0;
      bus_out    <= '0;
      valid_out  <= 1'b0;
      lane_out   <= 1'b0;
      overflow_0 <= 1'b0;
      overflow_1 <= 1'b0;
    end else begin
      // A write seen against a full lane is lost even if that lane pops now.
      overflow_0 <= overflow_0 | (valid_0 & full_0);
      overflow_1 <= overflow_1 | (valid_1 & full_1);
      if (load) begin
        rr_ptr    <= rr_nxt;
        valid_out <= gnt_vld;
        if (gnt_vld) begin
          bus_out  <= head;
          lane_out <= gnt;
        end
      end
    end
  end

`ifdef MUX_RR_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parity_out <= 1'b0;
    end else if (gnt_vld) begin
      parity_out <= ^head;
    end
  end
`endif

endmodule

// File: tb/tb_mux_rr_4_bits.sv
// Scoreboard bench for mux_rr_4_bits: directed pushes, monitor on handshakes.
// Optional parity checks follow MUX_RR_PARITY_EN.
module tb_mux_rr_4_bits;

  logic       clk;
  logic       reset;
  logic [3:0] deMux_4_bits_0;
  logic       valid_0;
  logic [3:0] deMux_4_bits_1;
  logic       valid_1;
  logic       ready;
  logic [3:0] bus_out;
  logic       valid_out;
  logic       lane_out;
  logic       full_0;
  logic       full_1;
  logic       overflow_0;
  logic       overflow_1;
`ifdef MUX_RR_PARITY_EN
  logic       parity_out;
`endif

  mux_rr_4_bits #(
    .WIDTH (4),
    .DEPTH (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .deMux_4_bits_0 (deMux_4_bits_0),
    .valid_0        (valid_0),
    .deMux_4_bits_1 (deMux_4_bits_1),
    .valid_1        (valid_1),
    .ready          (ready),
    .bus_out        (bus_out),
    .valid_out      (valid_out),
    .lane_out       (lane_out),
    .full_0         (full_0),
    .full_1         (full_1),
    .overflow_0     (overflow_0),
    .overflow_1     (overflow_1)
`ifdef MUX_RR_PARITY_EN
    ,
    .parity_out     (parity_out)
`endif
  );

  typedef struct {
    logic [3:0] d;
    logic       l;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", nm, act, want);
    end
  endtask

  task automatic sb_push(input logic [3:0] d, input logic l);
    exp_t e;
    e.d = d;
    e.l = l;
    q.push_back(e);
  endtask

  // Apply inputs for one rising edge; return 1 time unit after it.
  task automatic drive(input logic v0, input logic [3:0] d0,
                       input logic v1, input logic [3:0] d1);
    valid_0        = v0;
    deMux_4_bits_0 = d0;
    valid_1        = v1;
    deMux_4_bits_1 = d1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 4'h0, 1'b0, 4'h0);
  endtask

  task automatic do_reset();
    valid_0 = 1'b0;
    valid_1 = 1'b0;
    ready   = 1'b0;
    reset   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    q.delete();
  endtask

  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    valid_0 = 1'b0;
    valid_1 = 1'b0;
    while (q.size() != 0 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({nm, "_drain"}, 32'(q.size()), 32'd0);
    idle(2);
  endtask

  // Monitor: a transfer happens on the next edge when valid_out && ready.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && valid_out && ready) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_out: got %0h lane %0d, want none",
                 bus_out, lane_out);
      end else begin
        e = q.pop_front();
        check("bus_out", {28'd0, bus_out}, {28'd0, e.d});
        check("lane_out", {31'd0, lane_out}, {31'd0, e.l});
`ifdef MUX_RR_PARITY_EN
        check("parity_out", {31'd0, parity_out}, {31'd0, ^e.d});
`endif
      end
    end
  end

  initial begin
    reset          = 1'b1;
    valid_0        = 1'b0;
    valid_1        = 1'b0;
    ready          = 1'b0;
    deMux_4_bits_0 = 4'h0;
    deMux_4_bits_1 = 4'h0;
    #1;
    check("rst_bus", {28'd0, bus_out}, 32'd0);
    check("rst_valid", {31'd0, valid_out}, 32'd0);
    check("rst_lane", {31'd0, lane_out}, 32'd0);
    check("rst_full", {30'd0, full_1, full_0}, 32'd0);
    check("rst_ovf", {30'd0, overflow_1, overflow_0}, 32'd0);

    // Single lane, latency and order
    do_reset();
    ready = 1'b1;
    sb_push(4'h1, 1'b0);
    sb_push(4'h2, 1'b0);
    sb_push(4'h3, 1'b0);
    drive(1'b1, 4'h1, 1'b0, 4'h0);
    check("no_bypass", {31'd0, valid_out}, 32'd0);
    drive(1'b1, 4'h2, 1'b0, 4'h0);
    check("lat_valid", {31'd0, valid_out}, 32'd1);
    check("lat_bus", {28'd0, bus_out}, 32'h1);
    drive(1'b1, 4'h3, 1'b0, 4'h0);
    wait_drain("single");
    check("single_idle", {31'd0, valid_out}, 32'd0);

    // Round-robin
    do_reset();
    ready = 1'b1;
    sb_push(4'hA, 1'b0);
    sb_push(4'h5, 1'b1);
    sb_push(4'hB, 1'b0);
    sb_push(4'h6, 1'b1);
    drive(1'b1, 4'hA, 1'b1, 4'h5);
    drive(1'b1, 4'hB, 1'b1, 4'h6);
    wait_drain("rr");

    // Back-pressure on lane 1
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      drive(1'b0, 4'h0, 1'b1, 4'(i));
      if (i == 4) check("bp_full_early", {31'd0, full_1}, 32'd0);
    end
    valid_1 = 1'b0;
    check("bp_hold_bus", {28'd0, bus_out}, 32'h1);
    check("bp_hold_valid", {31'd0, valid_out}, 32'd1);
    check("bp_hold_lane", {31'd0, lane_out}, 32'd1);
    check("bp_full_1", {31'd0, full_1}, 32'd1);
    check("bp_full_0", {31'd0, full_0}, 32'd0);
    check("bp_ovf_1", {31'd0, overflow_1}, 32'd0);
    for (int i = 1; i <= 5; i++) sb_push(4'(i), 1'b1);
    ready = 1'b1;
    wait_drain("bp");
    check("bp_full_after", {31'd0, full_1}, 32'd0);
    check("bp_ovf_after", {31'd0, overflow_1}, 32'd0);

    // Overflow on lane 0 with ready low
    do_reset();
    for (int i = 0; i < 5; i++) drive(1'b1, 4'(8 + i), 1'b0, 4'h0);
    check("ovf_full_0", {31'd0, full_0}, 32'd1);
    check("ovf_pre", {31'd0, overflow_0}, 32'd0);
    drive(1'b1, 4'hF, 1'b0, 4'h0);
    check("ovf_set", {31'd0, overflow_0}, 32'd1);
    valid_0 = 1'b0;
    for (int i = 0; i < 5; i++) sb_push(4'(8 + i), 1'b0);
    ready = 1'b1;
    wait_drain("ovf");
    check("ovf_sticky", {31'd0, overflow_0}, 32'd1);
    check("ovf_ovf1", {31'd0, overflow_1}, 32'd0);
    check("ovf_valid", {31'd0, valid_out}, 32'd0);

    // Push to a full lane is dropped even while that lane pops
    do_reset();
    drive(1'b0, 4'h0, 1'b1, 4'h7);
    drive(1'b0, 4'h0, 1'b1, 4'h3);
    drive(1'b0, 4'h0, 1'b1, 4'h1);
    drive(1'b0, 4'h0, 1'b1, 4'h2);
    drive(1'b0, 4'h0, 1'b1, 4'h4);
    sb_push(4'h7, 1'b1);
    sb_push(4'h3, 1'b1);
    sb_push(4'h1, 1'b1);
    sb_push(4'h2, 1'b1);
    sb_push(4'h4, 1'b1);
    ready = 1'b1;
    drive(1'b0, 4'h0, 1'b1, 4'h9);
    check("dop_ovf", {31'd0, overflow_1}, 32'd1);
    check("dop_full", {31'd0, full_1}, 32'd0);
    wait_drain("dop");

    // Reset mid-operation with three entries in lane 0
    do_reset();
    for (int i = 1; i <= 4; i++) drive(1'b1, 4'(i), 1'b0, 4'h0);
    valid_0 = 1'b0;
    check("mid_pre_valid", {31'd0, valid_out}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_bus", {28'd0, bus_out}, 32'd0);
    check("mid_valid", {31'd0, valid_out}, 32'd0);
    check("mid_lane", {31'd0, lane_out}, 32'd0);
    check("mid_full", {30'd0, full_1, full_0}, 32'd0);
    check("mid_ovf", {30'd0, overflow_1, overflow_0}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    ready = 1'b1;
    idle(6);
    check("mid_no_data", {31'd0, valid_out}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running, want finished");
    $fatal(1);
  end

endmodule

// File: doc/mux_rr_4_bits.md
# mux_rr_4_bits

Two-lane 4-bit recombiner that sits directly downstream of the 4-bit demultiplexer stage. It buffers the nibbles arriving on the two demux output lanes in one small FIFO per lane and merges them back onto a single 4-bit output bus. Merging uses round-robin arbitration with a valid/ready handshake toward the next stage. Overflow on either lane is flagged and held until reset.

## Interface
- `WIDTH`, 4: data width of each lane and of the output bus.
- `DEPTH`, 4: entries per lane FIFO; power of two, at least 2.
- `clk`  input  1: single clock; all state updates on its rising edge.
- `reset`  input  1: asynchronous, active-high reset.
- `deMux_4_bits_0`  input  WIDTH: lane 0 data from the demux.
- `valid_0`  input  1: lane 0 data is valid this cycle.
- `deMux_4_bits_1`  input  WIDTH: lane 1 data from the demux.
- `valid_1`  input  1: lane 1 data is valid this cycle.
- `ready`  input  1: downstream accepts `bus_out` this cycle.
- `bus_out`  output  WIDTH: merged data, registered.
- `valid_out`  output  1: `bus_out` holds a nibble.
- `lane_out`  output  1: source lane of the current `bus_out`.
- `full_0`, `full_1`  output  1 each: lane FIFO holds DEPTH entries.
- `overflow_0`, `overflow_1`  output  1 each: sticky drop flag per lane.
- `parity_out`  output  1: present only with `MUX_RR_PARITY_EN`.

## Operation
- **Reset.** Asserting reset clears both FIFOs (pointers and count to 0) and sets the round-robin pointer to lane 0.
  - All outputs go to 0: `bus_out`, `valid_out`, `lane_out`, `full_*`, `overflow_*`, and `parity_out` when present.
  - Reset asserted mid-operation discards all buffered data immediately.
- **Push.**
  - Lane x writes its input when `valid_x` is high and `full_x` is low.
  - `full_x` is the value registered at the start of the cycle.
  - If `valid_x` is high while `full_x` is high, the nibble is dropped and `overflow_x` sets. It stays set until reset.
  - A push to a full FIFO is dropped even if the same cycle pops that FIFO.
- **Output register load.** The output register loads when `valid_out` is low or `ready` is high.
  - If both FIFOs are non-empty, grant the lane named by the RR pointer, then toggle the pointer.
  - If exactly one FIFO is non-empty, grant it. The pointer then points to the other lane.
  - If both FIFOs are empty, clear `valid_out`. `bus_out` holds its last value.
- **Pop.** The granted FIFO pops in the same cycle its head loads into `bus_out`. `lane_out` takes the granted lane index.
- **Stall.** When `valid_out` and `ready` are both low... more precisely, when `valid_out` is high and `ready` is low, `bus_out`, `lane_out` and `valid_out` hold. No FIFO pops.
- **Ordering.** Order is preserved within each lane. Interleaving between lanes follows the RR pointer only.
- **Pointers.** Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. Each count is log2(DEPTH)+1 bits.

## Timing
- **Latency.** A nibble pushed at edge N can appear on `bus_out` with `valid_out` high no earlier than edge N+1. There is no bypass of an empty FIFO.
- **Throughput.** One nibble per cycle on the output while `ready` is high and any FIFO is non-empty.
- **Full flags.** `full_x` is registered and rises on the edge that writes the DEPTH-th entry. It falls on the edge of the pop that frees a slot.
- **Overflow flags.** `overflow_x` rises on the edge following the dropped write.
- **Simultaneous push and pop on one lane.** When the lane is neither full nor empty, its count is unchanged.

## Configuration
- **`MUX_RR_PARITY_EN` defined:** `parity_out` exists. It is registered alongside `bus_out`, equals the XOR of `bus_out` (even parity), and holds during stalls.
- **`MUX_RR_PARITY_EN` undefined:** the port and its logic are absent. All other behaviour is identical.

## Structure
- **Shared package `mux_rr_pkg`:**
  - lane index type (1 bit);
  - constants `LANE_0` = 0 and `LANE_1` = 1;
  - the default WIDTH and DEPTH values.
- **Sub-module `fifo_lane`**, instantiated twice (one per lane).
  - Parameters: WIDTH and DEPTH.
  - Ports: `clk`, `reset`, `push`, `din`, `pop`, `dout` (head, combinational), `empty`, `full`.
- **Top level:** holds the RR pointer, the output register, and the overflow flags.

## Test plan
- **Reset mid-operation:** reset asserted with 3 entries in lane 0 and `valid_out` high -> all outputs 0 on the same cycle; no lane 0 data appears after reset is released.
- **Single lane:** lane 0 pushes 0x1, 0x2, 0x3 on consecutive cycles with `ready` high -> `bus_out` shows 0x1, 0x2, 0x3 on edges N+1..N+3; `lane_out` = 0 throughout.
- **Round-robin:** both lanes push simultaneously (lane 0: 0xA, 0xB; lane 1: 0x5, 0x6), `ready` high -> output sequence 0xA(0), 0x5(1), 0xB(0), 0x6(1).
- **Back-pressure:** `ready` held low while lane 1 pushes 5 nibbles 0x1..0x5 -> first nibble 0x1 held on `bus_out`; `full_1` high after 0x5; `overflow_1` stays 0. Releasing `ready` drains 0x1..0x5 in order.
- **Overflow:** with `ready` low and lane 0 full, push 0xF -> 0xF dropped; `overflow_0` = 1 next edge and stays set after the drain.
- **Parity (`MUX_RR_PARITY_EN`):** `bus_out` 0x7 -> `parity_out` = 1; `bus_out` 0x3 -> `parity_out` = 0.
